// File: rtl/lcd_host_seq.sv
// Command initiator for the 12x9 LCD zoom controller: issues commands, streams the image on LOAD
// and gathers the 16 returned beats. Optional macro LCD_TIMEOUT_EN adds a command timeout.
module lcd_host_seq #(
    parameter int IMG_PIXELS = 108,
    parameter int OUT_PIXELS = 16,
    parameter int TIMEOUT    = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_cmd,
    output logic       req_ready,
    output logic       img_rd,
    output logic [6:0] img_addr,
    input  logic [7:0] img_data,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] datain,
    input  logic       busy,
    input  logic [7:0] dataout,
    input  logic       output_valid,
    input  logic [3:0] res_addr,
    output logic [7:0] res_data,
    output logic       frame_done,
    output logic       error
);

    localparam int AW = 7;
    localparam int CW = 4;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_LOAD    = 3'd2,
        S_COLLECT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          state;
    logic [2:0]      cmd_lat;
    logic            load_act;
    logic [CW-1:0]   beat_cnt;
    logic [TW-1:0]   since;
    logic [7:0]      res_buf [0:OUT_PIXELS-1];
    logic            buf_we;

    // The ROM answers one cycle after img_rd, so the pixel stream is its output gated by a delayed strobe.
    assign datain   = load_act ? img_data : 8'd0;
    assign res_data = res_buf[res_addr];
    assign buf_we   = (state == S_COLLECT) && output_valid;

    // Result buffer: written by captured beats, deliberately never reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            res_buf[beat_cnt] <= dataout;
        end
    end

    // Command sequencer with all handshake outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cmd_lat    <= 3'd0;
            req_ready  <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd        <= 3'd0;
            img_rd     <= 1'b0;
            img_addr   <= 7'd0;
            load_act   <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
            beat_cnt   <= '0;
            since      <= '0;
        end else begin
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (since != {TW{1'b1}}) begin
                since <= since + TW'(1);
            end
            if (output_valid && (state != S_COLLECT)) begin
                error <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        cmd_lat   <= req_cmd;
                        if (req_cmd == 3'd7) begin
                            error      <= 1'b1;
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!busy) begin
                        cmd_valid <= 1'b1;
                        cmd       <= cmd_lat;
                        since     <= '0;
                        beat_cnt  <= '0;
                        if (cmd_lat == 3'd0) begin
                            img_rd   <= 1'b1;
                            img_addr <= 7'd0;
                            state    <= S_LOAD;
                        end else begin
                            state <= S_COLLECT;
                        end
                    end
                end
                S_LOAD: begin
                    if (img_rd) begin
                        if (img_addr == AW'(IMG_PIXELS - 1)) begin
                            img_rd   <= 1'b0;
                            img_addr <= 7'd0;
                        end else begin
                            img_addr <= img_addr + 7'd1;
                        end
                    end
                    load_act <= img_rd;
                    // Last pixel has just been driven once the delayed strobe outlives the read strobe.
                    if (load_act && !img_rd) begin
                        state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (output_valid) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if (beat_cnt == CW'(OUT_PIXELS - 1)) begin
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end
                    end else if (!busy && (since >= TW'(2))) begin
                        error      <= 1'b1;
                        frame_done <= 1'b1;
                        state      <= S_DONE;
                    end
`ifdef LCD_TIMEOUT_EN
                    else if (since == TW'(TIMEOUT - 1)) begin
                        error      <= 1'b1;
                        frame_done <= 1'b1;
                        state      <= S_DONE;
                    end
`endif
                end
                S_DONE: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_host_seq.sv
// Self-checking bench for lcd_host_seq: a reactive LCD controller model plus a window/position
// reference that predicts each 16-beat result from the image contents.
module tb_lcd_host_seq;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_cmd;
    logic       req_ready;
    logic       img_rd;
    logic [6:0] img_addr;
    logic [7:0] img_data;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic [7:0] datain;
    logic       busy;
    logic [7:0] dataout;
    logic       output_valid;
    logic [3:0] res_addr;
    logic [7:0] res_data;
    logic       frame_done;
    logic       error;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int hang = 0;
    int stray_req = 0;

    logic [7:0] rom   [0:107];
    logic [7:0] beats [0:15];
    logic [7:0] held  [0:15];
    logic [7:0] fit_exp [0:15];
    int  ex_x, ex_y;
    bit  ex_fit;

    lcd_host_seq dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_ready(req_ready), .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
        .cmd(cmd), .cmd_valid(cmd_valid), .datain(datain), .busy(busy),
        .dataout(dataout), .output_valid(output_valid), .res_addr(res_addr),
        .res_data(res_data), .frame_done(frame_done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous image ROM
    always @(posedge clk) if (img_rd) img_data <= rom[img_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] win(input int b);
        int r, c;
        r = ex_fit ? 1 + 2 * (b / 4) : ex_y + b / 4;
        c = ex_fit ? 1 + 3 * (b % 4) : ex_x + b % 4;
        return rom[r * 12 + c];
    endfunction

    task automatic apply_pos(input int c);
        case (c)
            0: begin ex_fit = 1; ex_x = 4; ex_y = 3; end
            1: if (ex_fit) begin ex_fit = 0; ex_x = 4; ex_y = 3; end
            2: ex_fit = 1;
            3: if (!ex_fit && ex_x < 8) ex_x++;
            4: if (!ex_fit && ex_x > 0) ex_x--;
            5: if (!ex_fit && ex_y > 0) ex_y--;
            6: if (!ex_fit && ex_y < 5) ex_y++;
            default: ;
        endcase
    endtask

    // LCD controller model: busy from cmd_valid, captures the pixel stream, returns beats with random gaps.
    initial begin : lcd_model
        int stray_seen;
        bit ab;
        stray_seen = 0;
        busy = 1'b0; output_valid = 1'b0; dataout = 8'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 1'b0; output_valid = 1'b0;
            end else if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                output_valid = 1'b1; dataout = 8'hA5;
                @(negedge clk);
                output_valid = 1'b0;
            end else if (cmd_valid) begin
                ab = 0;
                busy = 1'b1;
                if (cmd == 3'd0) begin
                    for (int k = 0; k < 108; k++) begin
                        @(negedge clk);
                        if (reset) begin ab = 1; break; end
                        check("datain_pixel", datain, rom[k]);
                    end
                end
                if (!ab && hang != 0) begin
                    while (!reset) @(negedge clk);
                    ab = 1;
                end
                if (!ab) begin
                    for (int b = 0; b < 16; b++) begin
                        repeat ($urandom_range(0, 2) + 1) begin
                            @(negedge clk);
                            output_valid = 1'b0;
                        end
                        output_valid = 1'b1;
                        dataout = beats[b];
                        busy = (b != 15);
                    end
                    @(negedge clk);
                    output_valid = 1'b0;
                    busy = 1'b0;
                end
                if (ab) begin busy = 1'b0; output_valid = 1'b0; end
            end
        end
    end

    task automatic run_cmd(input logic [2:0] c, input int budget, output int cv_at, output int fd_at);
        int ncv;
        ncv = 0; cv_at = -1; fd_at = -1;
        apply_pos(int'(c));
        for (int b = 0; b < 16; b++) beats[b] = win(b);
        @(negedge clk);
        for (int i = 0; i < budget && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1; req_cmd = c;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cmd_valid) begin
                ncv++;
                if (cv_at < 0) cv_at = cyc;
                check("cmd_value", cmd, c);
            end
            if (frame_done) begin fd_at = cyc; break; end
            @(negedge clk);
        end
        check("cmd_valid_count", ncv, (c == 3'd7) ? 0 : 1);
        if (fd_at >= 0) begin
            @(negedge clk);
            check("frame_done_single", frame_done, 1'b0);
            check("ready_after_done", req_ready, 1'b1);
        end
    endtask

    task automatic check_buf(input string tag);
        for (int i = 0; i < 16; i++) begin
            res_addr = 4'(i);
            #1;
            check(tag, res_data, held[i]);
        end
    endtask

    task automatic chk_at(input string tag, input int idx, input logic [7:0] v);
        res_addr = 4'(idx);
        #1;
        check(tag, res_data, v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        hang = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        int cv, fd;
        logic [2:0] rc;
        reset = 1'b1; req_valid = 1'b0; req_cmd = 3'd0; res_addr = 4'd0;
        for (int i = 0; i < 108; i++) rom[i] = 8'(i);
        fit_exp = '{8'd13, 8'd16, 8'd19, 8'd22, 8'd37, 8'd40, 8'd43, 8'd46,
                    8'd61, 8'd64, 8'd67, 8'd70, 8'd85, 8'd88, 8'd91, 8'd94};
        ex_fit = 1; ex_x = 4; ex_y = 3;
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_cmd", cmd, 3'd0);
        check("rst_datain", datain, 8'd0);
        check("rst_img_rd", img_rd, 1'b0);
        check("rst_img_addr", img_addr, 7'd0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_error", error, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_req_ready", req_ready, 1'b1);

        // Load with ROM[i]=i, then zoom-in and right
        run_cmd(3'd0, 400, cv, fd);
        check("load_done", fd >= 0, 1'b1);
        held = beats;
        check_buf("load_buf");
        for (int i = 0; i < 16; i++) chk_at("load_fit_literal", i, fit_exp[i]);
        check("load_error", error, 1'b0);
        run_cmd(3'd1, 200, cv, fd);
        held = beats;
        check_buf("zoomin_buf");
        chk_at("zoomin_first", 0, 8'd40);
        chk_at("zoomin_last", 15, 8'd79);
        run_cmd(3'd3, 200, cv, fd);
        held = beats;
        check_buf("right_buf");
        chk_at("right_first", 0, 8'd41);
        chk_at("right_last", 15, 8'd80);

        // Zoom-in then eight rights clamps at the right edge
        run_cmd(3'd1, 200, cv, fd);
        for (int i = 0; i < 8; i++) run_cmd(3'd3, 200, cv, fd);
        held = beats;
        for (int i = 0; i < 4; i++) chk_at("clamp_row0", i, 8'(44 + i));
        check("clamp_error", error, 1'b0);

        // Random image and random command sequence
        for (int i = 0; i < 108; i++) rom[i] = 8'($urandom);
        run_cmd(3'd0, 400, cv, fd);
        held = beats;
        check_buf("rand_load_buf");
        for (int n = 0; n < 12; n++) begin
            rc = 3'($urandom_range(1, 6));
            run_cmd(rc, 200, cv, fd);
            check("rand_done", fd >= 0, 1'b1);
            held = beats;
            check_buf("rand_buf");
            check("rand_error", error, 1'b0);
        end

        // Command 7: accepted, not issued, error plus frame_done
        run_cmd(3'd7, 50, cv, fd);
        check("cmd7_done", fd >= 0, 1'b1);
        check("cmd7_error", error, 1'b1);
        check_buf("cmd7_buf");
        do_reset();
        check("reset_clears_error", error, 1'b0);

        // Stray output_valid while idle
        stray_req++;
        repeat (4) @(negedge clk);
        check("stray_error", error, 1'b1);
        check_buf("stray_buf");
        do_reset();

        // Reset at pixel 50 of a load
        for (int i = 0; i < 108; i++) rom[i] = 8'($urandom);
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 3'd0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 50 && !cmd_valid; i++) @(negedge clk);
        check("midload_cmd_valid", cmd_valid, 1'b1);
        repeat (51) @(negedge clk);
        check("midload_img_rd", img_rd, 1'b1);
        check("midload_pixel50", datain, rom[50]);
        reset = 1'b1;
        #1;
        check("midload_rst_cmd_valid", cmd_valid, 1'b0);
        check("midload_rst_img_rd", img_rd, 1'b0);
        check("midload_rst_frame_done", frame_done, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midload_ready", req_ready, 1'b1);
        check_buf("midload_buf_kept");
        run_cmd(3'd0, 400, cv, fd);
        check("reload_done", fd >= 0, 1'b1);
        held = beats;
        check_buf("reload_buf");
        check("reload_error", error, 1'b0);

        // Controller hangs with busy high and no beats
        hang = 1;
        run_cmd(3'd2, 700, cv, fd);
`ifdef LCD_TIMEOUT_EN
        check("timeout_seen", fd >= 0, 1'b1);
        check("timeout_latency", fd - cv, 512);
        check("timeout_error", error, 1'b1);
`else
        check("hang_no_done", fd, 32'hFFFF_FFFF);
        check("hang_no_error", error, 1'b0);
        check("hang_not_ready", req_ready, 1'b0);
`endif
        do_reset();
        check("final_ready", req_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_host_seq.md
Name: lcd_host_seq

Overview:
Command initiator for the 12x9 LCD zoom controller. It accepts high-level commands from an upstream host and drives the controller's cmd/cmd_valid/datain side. It streams a 108-pixel image from a synchronous image ROM on LOAD, then collects the 16 output_valid beats of every command into a readable result buffer. It sits between the host/testbench script and the LCD controller, and owns all busy-handshake timing.

Parameters:
IMG_PIXELS, 108, pixels streamed after a LOAD command (12x9 image)
OUT_PIXELS, 16, output_valid beats returned per command (4x4 window)
TIMEOUT, 512, max cycles a command may stay outstanding before error (LCD_TIMEOUT_EN only)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  host command request
req_cmd  input  3  0 load, 1 zoom-in, 2 zoom-fit, 3 right, 4 left, 5 up, 6 down
req_ready  output  1  high in IDLE only; request accepted when req_valid & req_ready
img_rd  output  1  image ROM read strobe
img_addr  output  7  image ROM address, 0..IMG_PIXELS-1
img_data  input  8  ROM data, valid one cycle after img_rd
cmd  output  3  command to LCD controller
cmd_valid  output  1  single-cycle command strobe to LCD controller
datain  output  8  pixel stream to LCD controller
busy  input  1  LCD controller busy
dataout  input  8  LCD controller output pixel
output_valid  input  1  LCD controller output strobe
res_addr  input  4  result buffer read index
res_data  output  8  result buffer content at res_addr (combinational read)
frame_done  output  1  one-cycle pulse when a command's 16 beats complete
error  output  1  sticky protocol error flag, cleared by reset only

Behaviour:
- Reset values: req_ready 0 for the reset cycle then 1 in IDLE; cmd_valid 0, cmd 0, datain 0, img_rd 0, img_addr 0, frame_done 0, error 0. Result buffer contents are not reset.
- FSM states: IDLE, ISSUE, LOAD, COLLECT, DONE.
- IDLE: req_ready=1. On req_valid, latch req_cmd and go to ISSUE.
- ISSUE: wait for busy==0. In the first such cycle, assert cmd_valid=1 with cmd=latched value for exactly one cycle.
  - If cmd==0: also assert img_rd=1 with img_addr=0 in that same cycle, then go to LOAD.
  - Otherwise go to COLLECT.
- LOAD: call the cmd_valid cycle N. datain carries pixel k in cycle N+1+k, for k=0..107, with no gaps; datain is img_data passed through.
  - img_rd stays high with img_addr incrementing through 107, then drops.
  - After pixel 107 is driven, go to COLLECT (the controller auto zoom-fits after a load).
- COLLECT:
  - Beat counter 0..15. Each output_valid beat writes dataout to buffer[counter] and increments the counter.
  - When beat 15 is captured (busy falls in that same cycle), go to DONE.
  - busy==0 with no output_valid and counter<16, observed at least 2 cycles after cmd_valid: set error and go to DONE.
- DONE: frame_done=1 for one cycle, then return to IDLE. No new cmd_valid is possible before the cycle after DONE.
- output_valid seen outside COLLECT: set error; data is ignored.
- Requests are never queued. req_valid while req_ready=0 is ignored, and the host must hold it.
- Commands 3-6 are forwarded unchanged. Window clamping is the controller's job; this block only collects the 16 beats.
- req_cmd 7: accepted but not issued. Set error, pulse frame_done, return to IDLE.
- Async reset mid-LOAD or mid-COLLECT returns to IDLE immediately: cmd_valid and img_rd drop, the partial buffer is left as is, and frame_done is not pulsed.

Optional Feature:
LCD_TIMEOUT_EN:
- Defined: a cycle counter runs from the cmd_valid cycle. If COLLECT has not completed after TIMEOUT cycles, set error, go to DONE (frame_done pulses), then IDLE.
- Undefined: no counter; the block waits indefinitely for busy/output_valid.

Test Plan:
1. Reset, then req cmd 0 with ROM[i]=i -> cmd_valid one cycle; datain 0..107 on consecutive cycles starting N+1; buffer = {13,16,19,22,37,40,43,46,61,64,67,70,85,88,91,94}; frame_done once; error 0.
2. After 1, req cmd 1 then cmd 3 -> buffer rows {40..43,52..55,64..67,76..79}, then {41..44,53..56,65..68,77..80}.
3. Zoom-in then eight cmd 3 (right) -> last buffer row0 = {8,9,10,11}+36 = {44,45,46,47}; no error.
4. Model holds busy high and never returns beats, with LCD_TIMEOUT_EN and TIMEOUT=512 -> error=1 and frame_done exactly 512 cycles after cmd_valid; without the macro, FSM stays in COLLECT.
5. Stray output_valid pulse while IDLE -> error=1; buffer unchanged.
6. Assert reset at pixel 50 of a LOAD -> cmd_valid/img_rd 0 next edge; req_ready 1 after release; a fresh cmd 0 completes normally.
